// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port between
// the ALU writeback (port A) and the load-return path (port B).
module regbank_write_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_grant
);

  logic              last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Under contention the port that did not win last time gets the grant.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rstn && !hold) begin
      if (a_valid && b_valid) begin
        a_ready = last_grant_q;
        b_ready = !last_grant_q;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  always_comb begin
    xfer         = a_ready | b_ready;
    win_addr     = b_ready ? b_addr : a_addr;
    win_data     = b_ready ? b_data : a_data;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_sel_d     = wr_sel_q;
    wr_data_d    = wr_data_q;
    if (xfer) begin
      last_grant_d = b_ready;
      wr_sel_d     = b_ready;
      wr_addr_d    = win_addr;
      wr_data_d    = win_data;
      // An r0 handshake still completes and moves the pointer; only the write is suppressed.
      wr_en_d      = !(DROP_R0 && (win_addr == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_sel_q     <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_sel_q     <= wr_sel_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_sel     = wr_sel_q;
  assign wr_data    = wr_data_q;
  assign last_grant = last_grant_q;

endmodule
